transmit_packet: RTL and testbench

Reads a frame of bytes from the shared 32-bit packet RAM and sends it to the Ethernet MAC transmit FIFO. Data goes out over Avalon-ST, one byte per beat. It is the transmit counterpart of the receive path that writes frames into the same RAM. A single `tx_start` pulse with a base word address and a byte length launches a frame. `data_sent` pulses once the last byte has been accepted by the MAC.

---
 rtl/transmit_packet_pkg.sv | 14 +
 rtl/tx_byte_serializer.sv | 48 ++++
 rtl/transmit_packet.sv | 162 ++++++++++++++++
 tb/tb_transmit_packet.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/transmit_packet_pkg.sv
// Shared types and constants for the packet-RAM transmit path.
package transmit_packet_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRdReq,
    StSend,
    StDone
  } tx_state_e;

  localparam int unsigned MIN_FRAME_LEN  = 60;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/tx_byte_serializer.sv
// 32-to-8 width converter: holds one RAM word and presents it a byte per beat, lane 0 first.
module tx_byte_serializer
  import transmit_packet_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        valid_i,
  input  logic        ready_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        accept_o,
  output logic        last_lane_o
);

  localparam int unsigned LaneW = $clog2(BYTES_PER_WORD);

  logic [31:0]      word_q, word_d;
  logic [LaneW-1:0] lane_q, lane_d;

  assign accept_o    = valid_i & ready_i;
  assign valid_o     = valid_i;
  assign last_lane_o = (lane_q == LaneW'(BYTES_PER_WORD - 1));
  assign data_o      = valid_i ? word_q[{lane_q, 3'b000} +: 8] : 8'h00;

  always_comb begin
    word_d = word_q;
    lane_d = lane_q;
    if (load_i) begin
      word_d = word_i;
      lane_d = '0;
    end else if (accept_o) begin
      lane_d = lane_q + LaneW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
      lane_q <= '0;
    end else begin
      word_q <= word_d;
      lane_q <= lane_d;
    end
  end

endmodule

// File: rtl/transmit_packet.sv
// Streams a frame from packet RAM to the MAC transmit FIFO, one byte per Avalon-ST beat.
// Optional short-frame zero padding to 60 bytes is enabled by defining TX_PAD_EN.
module transmit_packet
  import transmit_packet_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LEN_W   = 12,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic              clk_original,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [ADDR_W-1:0] tx_base_addr,
  input  logic [LEN_W-1:0]  tx_length,
  output logic              tx_busy,
  output logic              tx_len_err,
  output logic              data_sent,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_chipselect,
  output logic              ram_read,
  input  logic [31:0]       ram_readdata,
  output logic [3:0]        ram_byteenable,
  input  logic              ram_waitrequest,
  output logic [7:0]        ff_tx_data,
  output logic              ff_tx_sop,
  output logic              ff_tx_eop,
  output logic              ff_tx_wren,
  input  logic              ff_tx_rdy,
  output logic              ff_tx_err,
  output logic              ff_tx_crc_fwd
);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              len_err_q, len_err_d;

  logic              len_ok, load, sending, accept, last_lane, is_eop, need_word;
  logic [LEN_W-1:0]  frame_len;
  logic [7:0]        ser_data;

`ifdef TX_PAD_EN
  logic [LEN_W-1:0]  data_len_q, data_len_d;
  logic              pad_zone;

  // len_q counts wire bytes; data_len_q counts the bytes that actually live in RAM.
  assign frame_len = (tx_length < LEN_W'(MIN_FRAME_LEN)) ? LEN_W'(MIN_FRAME_LEN) : tx_length;
  assign pad_zone  = (byte_cnt_q >= data_len_q);
  assign need_word = ((byte_cnt_q + LEN_W'(1)) < data_len_q);
  assign ff_tx_data = pad_zone ? 8'h00 : ser_data;
`else
  assign frame_len  = tx_length;
  assign need_word  = 1'b1;
  assign ff_tx_data = ser_data;
`endif

  assign len_ok = (tx_length != '0) && (tx_length <= LEN_W'(MAX_LEN));
  assign is_eop = sending && (byte_cnt_q == len_q - LEN_W'(1));

  assign ff_tx_sop     = sending && (byte_cnt_q == '0);
  assign ff_tx_eop     = is_eop;
  assign ff_tx_err     = 1'b0;
  assign ff_tx_crc_fwd = 1'b0;
  assign tx_busy       = (state_q != StIdle);
  assign data_sent     = (state_q == StDone);
  assign tx_len_err    = len_err_q;

  tx_byte_serializer u_ser (
    .clk_i       (clk_original),
    .rst_i       (rst),
    .load_i      (load),
    .word_i      (ram_readdata),
    .valid_i     (sending),
    .ready_i     (ff_tx_rdy),
    .data_o      (ser_data),
    .valid_o     (ff_tx_wren),
    .accept_o    (accept),
    .last_lane_o (last_lane)
  );

  always_comb begin
    state_d        = state_q;
    cur_addr_d     = cur_addr_q;
    len_d          = len_q;
    byte_cnt_d     = byte_cnt_q;
    len_err_d      = 1'b0;
    load           = 1'b0;
    sending        = 1'b0;
    ram_chipselect = 1'b0;
    ram_read       = 1'b0;
    ram_byteenable = 4'h0;
    ram_addr       = '0;
`ifdef TX_PAD_EN
    data_len_d     = data_len_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (tx_start) begin
          if (len_ok) begin
            cur_addr_d = tx_base_addr;
            len_d      = frame_len;
            byte_cnt_d = '0;
`ifdef TX_PAD_EN
            data_len_d = tx_length;
`endif
            state_d    = StRdReq;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      StRdReq: begin
        ram_chipselect = 1'b1;
        ram_read       = 1'b1;
        ram_byteenable = 4'hF;
        ram_addr       = cur_addr_q;
        if (!ram_waitrequest) begin
          load       = 1'b1;
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          state_d    = StSend;
        end
      end
      StSend: begin
        sending = 1'b1;
        if (accept) begin
          byte_cnt_d = byte_cnt_q + LEN_W'(1);
          if (is_eop) begin
            state_d = StDone;
          end else if (last_lane && need_word) begin
            state_d = StRdReq;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_original) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_addr_q <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      len_err_q  <= 1'b0;
`ifdef TX_PAD_EN
      data_len_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      len_err_q  <= len_err_d;
`ifdef TX_PAD_EN
      data_len_q <= data_len_d;
`endif
    end
  end

endmodule

// File: tb/tb_transmit_packet.sv
// Directed bench for transmit_packet: table of frame vectors plus hand sequences for
// length errors and mid-frame reset. Honours TX_PAD_EN for expected frame length.
module tb_transmit_packet;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, tx_start;
  logic [9:0]  tx_base_addr;
  logic [11:0] tx_length;
  logic        tx_busy, tx_len_err, data_sent;
  logic [9:0]  ram_addr;
  logic        ram_chipselect, ram_read, ram_waitrequest;
  logic [31:0] ram_readdata;
  logic [3:0]  ram_byteenable;
  logic [7:0]  ff_tx_data;
  logic        ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_rdy, ff_tx_err, ff_tx_crc_fwd;

  logic [31:0] mem [0:1023];
  assign ram_readdata = mem[ram_addr];

  int total = 0;
  int bad   = 0;

  transmit_packet dut (
    .clk_original    (clk),
    .rst             (rst),
    .tx_start        (tx_start),
    .tx_base_addr    (tx_base_addr),
    .tx_length       (tx_length),
    .tx_busy         (tx_busy),
    .tx_len_err      (tx_len_err),
    .data_sent       (data_sent),
    .ram_addr        (ram_addr),
    .ram_chipselect  (ram_chipselect),
    .ram_read        (ram_read),
    .ram_readdata    (ram_readdata),
    .ram_byteenable  (ram_byteenable),
    .ram_waitrequest (ram_waitrequest),
    .ff_tx_data      (ff_tx_data),
    .ff_tx_sop       (ff_tx_sop),
    .ff_tx_eop       (ff_tx_eop),
    .ff_tx_wren      (ff_tx_wren),
    .ff_tx_rdy       (ff_tx_rdy),
    .ff_tx_err       (ff_tx_err),
    .ff_tx_crc_fwd   (ff_tx_crc_fwd)
  );

  typedef struct {
    logic [9:0] base;
    int         len;
    int         stall_beat;  // beat index held off by rdy=0 (-1: none)
    int         stall_n;
    int         wait_read;   // read index stalled by waitrequest (-1: none)
    int         wait_n;
    int         exp_reads;
    logic [9:0] exp_addr1;
    int         exp_sent;    // data_sent cycle without padding (0: not checked)
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [9:0] base, input int len, input int i);
    logic [31:0] w;
    logic [9:0]  a;
    if (i >= len) return 8'h00;
    a = base + 10'(i / 4);
    w = mem[a];
    return w[8 * (i % 4) +: 8];
  endfunction

  function automatic int wire_len(input int len);
`ifdef TX_PAD_EN
    return (len < 60) ? 60 : len;
`else
    return len;
`endif
  endfunction

  function automatic logic [31:0] all_outs();
    return {tx_busy, tx_len_err, data_sent, ram_addr, ram_chipselect, ram_read, ram_byteenable,
            ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_err, ff_tx_crc_fwd};
  endfunction

  task automatic run_frame(input vec_t v, input string tag);
    int nbeats = 0, nreads = 0, nsent = 0;
    int stall_left = v.stall_n, wait_left = v.wait_n;
    int elen, last_acc = -1, sent_cyc = -1, first_cyc = -1;
    bit err_seen = 0, done = 0;
    elen = wire_len(v.len);
    @(negedge clk);
    tx_start = 1'b1; tx_base_addr = v.base; tx_length = 12'(v.len);
    @(negedge clk);
    tx_start = 1'b0;
    for (int c = 1; c < 400 && !done; c++) begin
      if (c > 1) @(negedge clk);
      // A start while busy must be ignored (length 0 would otherwise flag an error).
      tx_start  = (c == 3);
      tx_length = (c == 3) ? 12'd0 : 12'(v.len);
      if (tx_len_err) err_seen = 1;
      if (c == 1) begin
        check({tag, " strobe@1"}, ram_read, 1'b1);
        check({tag, " busy@1"}, tx_busy, 1'b1);
      end
      ram_waitrequest = 1'b0;
      if (ram_read && nreads == v.wait_read && wait_left > 0) begin
        ram_waitrequest = 1'b1;
        wait_left--;
      end
      if (ram_read && !ram_waitrequest) begin
        check({tag, " be"}, ram_byteenable, 4'hF);
        if (nreads == 0) check({tag, " addr0"}, ram_addr, v.base);
        if (nreads == 1) check({tag, " addr1"}, ram_addr, v.exp_addr1);
        nreads++;
      end
      check({tag, " rd/wren overlap"}, ram_read & ff_tx_wren, 1'b0);
      ff_tx_rdy = 1'b1;
      if (ff_tx_wren && nbeats == v.stall_beat && stall_left > 0) begin
        ff_tx_rdy = 1'b0;
        stall_left--;
      end
      if (ff_tx_wren) begin
        check($sformatf("%s byte%0d", tag, nbeats), ff_tx_data, exp_byte(v.base, v.len, nbeats));
        check($sformatf("%s sop%0d", tag, nbeats), ff_tx_sop, nbeats == 0);
        check($sformatf("%s eop%0d", tag, nbeats), ff_tx_eop, nbeats == elen - 1);
        if (ff_tx_rdy) begin
          if (nbeats == 0) first_cyc = c;
          nbeats++;
          last_acc = c;
        end
      end
      if (data_sent) begin
        nsent++;
        if (sent_cyc < 0) sent_cyc = c;
      end else if (sent_cyc >= 0) begin
        check({tag, " busy after done"}, tx_busy, 1'b0);
        check({tag, " read after done"}, ram_read, 1'b0);
        done = 1;
      end
    end
    tx_start = 1'b0;
    check({tag, " finished"}, done, 1'b1);
    check({tag, " beats"}, nbeats, elen);
    check({tag, " reads"}, nreads, v.exp_reads);
    check({tag, " sent pulses"}, nsent, 1);
    check({tag, " sent timing"}, sent_cyc, last_acc + 1);
    check({tag, " no err"}, err_seen, 1'b0);
    if (v.wait_read != 0) check({tag, " first byte@2"}, first_cyc, 2);
`ifndef TX_PAD_EN
    if (v.exp_sent != 0) check({tag, " sent cycle"}, sent_cyc, v.exp_sent);
`endif
  endtask

  task automatic len_err_case(input int len, input string tag);
    @(negedge clk);
    tx_start = 1'b1; tx_base_addr = 10'h010; tx_length = 12'(len);
    @(negedge clk);
    tx_start = 1'b0;
    check({tag, " err pulse"}, tx_len_err, 1'b1);
    check({tag, " busy"}, tx_busy, 1'b0);
    check({tag, " read"}, ram_read, 1'b0);
    @(negedge clk);
    check({tag, " err cleared"}, tx_len_err, 1'b0);
    check({tag, " still idle"}, {tx_busy, ram_read}, 2'b00);
  endtask

  initial begin
    bit hit;
    int nb;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h01010101 + 32'h10203040;
    mem[10'h010] = 32'h04030201;
    mem[10'h011] = 32'h08070605;
    mem[10'h3FF] = 32'h44332211;
    mem[10'h000] = 32'h88776655;

    vecs[0] = '{10'h010, 8,  -1, 0, -1, 0, 2, 10'h011, 11};
    vecs[1] = '{10'h010, 5,  -1, 0, -1, 0, 2, 10'h011, 8};
    vecs[2] = '{10'h010, 8,   1, 3,  1, 2, 2, 10'h011, 0};
    vecs[3] = '{10'h3FF, 8,  -1, 0, -1, 0, 2, 10'h000, 11};
    vecs[4] = '{10'h020, 10, -1, 0, -1, 0, 3, 10'h021, 14};
    vecs[5] = '{10'h030, 1,  -1, 0, -1, 0, 1, 10'h031, 3};

    rst = 1'b1; tx_start = 1'b0; tx_base_addr = '0; tx_length = '0;
    ram_waitrequest = 1'b0; ff_tx_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check("reset outputs", all_outs(), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("v%0d", i));

    len_err_case(0, "len0");
    len_err_case(1519, "len1519");

    // Reset while the third byte is on the bus.
    @(negedge clk);
    tx_start = 1'b1; tx_base_addr = 10'h010; tx_length = 12'd8;
    @(negedge clk);
    tx_start = 1'b0;
    hit = 0; nb = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (ff_tx_wren && nb == 2) hit = 1;
      else begin
        if (ff_tx_wren) nb++;
        @(negedge clk);
      end
    end
    check("rst reached byte3", hit, 1'b1);
    check("rst byte3 data", ff_tx_data, 8'h03);
    rst = 1'b1;
    @(negedge clk);
    check("mid-frame reset outputs", all_outs(), 32'h0);
    rst = 1'b0;
    run_frame(vecs[0], "after rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
